// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the FIFO, absorbs its one-cycle read latency in a
// 2-entry buffer and streams words out. Burst framing is built with FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream #(
    parameter int W_DATA    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [W_DATA-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W_DATA-1:0] m_data,
    output logic              m_last,
    output logic [7:0]        beat_cnt
);

    if (BURST_LEN < 2 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("BURST_LEN must be in 2..256");
    end

    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [W_DATA-1:0] head_q, head_d;
    logic [W_DATA-1:0] tail_q, tail_d;
    logic              xfer;
    logic [2:0]        occ;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;
    assign xfer    = m_valid && m_ready;

    // Occupancy once this cycle's beat leaves and the in-flight word lands.
    assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, xfer};
    assign fifo_pop = !rst && !fifo_empty && (occ < 3'd2);

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_pop;
        case ({inflight_q, xfer})
            2'b10: begin
                if (count_q == 2'd0) head_d = fifo_data;
                else                 tail_d = fifo_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = fifo_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] beat_q, beat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // An empty FIFO holds the burst open; only transferred beats advance it.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (xfer) begin
            if (beat_q == LAST_BEAT) begin
                state_d = S_IDLE;
                beat_d  = 8'd0;
            end else if (state_q == S_IDLE) begin
                state_d = S_ACTIVE;
                beat_d  = 8'd1;
            end else begin
                beat_d  = beat_q + 8'd1;
            end
        end
    end

    always_comb begin
        m_last   = m_valid && (beat_q == LAST_BEAT);
        beat_cnt = beat_q;
    end
`else
    assign m_last   = 1'b0;
    assign beat_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, scoreboard of popped words,
// table of streaming vectors plus hand-written latency and reset sequences.
module tb_fifo_rd_stream;

    localparam int W_DATA    = 8;
    localparam int BURST_LEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [W_DATA-1:0] fifo_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [W_DATA-1:0] m_data;
    logic              m_last;
    logic [7:0]        beat_cnt;

    fifo_rd_stream #(.W_DATA(W_DATA), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W_DATA-1:0] fifo_q[$];
    logic [W_DATA-1:0] exp_q[$];

    int                tb_beat    = 0;
    logic              stall_prev = 1'b0;
    logic [W_DATA-1:0] prev_data  = '0;
    int                run_beats  = 0;
    int                first_cyc  = 0;
    int                last_cyc   = 0;
    bit                mon_en     = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: pop sampled mid-cycle, data returned one cycle later
    initial begin
        logic              pop_s;
        logic [W_DATA-1:0] w;
        fifo_data  = 8'hEE;
        fifo_empty = 1'b1;
        w          = '0;
        forever begin
            @(negedge clk);
            #1;
            pop_s = fifo_pop && !fifo_empty && (fifo_q.size() > 0);
            if (pop_s) begin
                w = fifo_q.pop_front();
                exp_q.push_back(w);
            end
            @(posedge clk);
            #1;
            fifo_data  = pop_s ? w : 8'hEE;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Stream monitor / scoreboard
    initial forever begin
        logic exp_last;
        @(negedge clk);
        if (mon_en && !rst) begin
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
`ifdef FIFO_RD_STREAM_LAST_EN
            exp_last = m_valid && (tb_beat == BURST_LEN - 1);
            chk("beat_cnt", beat_cnt, tb_beat);
`else
            exp_last = 1'b0;
            chk("beat_cnt", beat_cnt, 0);
`endif
            chk("m_last", m_last, exp_last);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_data, 'hFFFF);
                end else begin
                    chk("beat_data", m_data, exp_q.pop_front());
                end
                tb_beat = exp_last ? 0 : tb_beat + 1;
                if (run_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                run_beats++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        tb_beat    = 0;
        stall_prev = 1'b0;
        rst        = 1'b0;
    endtask

    typedef struct {
        int                n_words;
        logic [W_DATA-1:0] base;
        logic [3:0]        rpat;
        int                exp_span;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int k;
        int pops;
        bit seen;

        vecs[0] = '{n_words: 8,  base: 8'h00, rpat: 4'b1111, exp_span: 8};
        vecs[1] = '{n_words: 8,  base: 8'h10, rpat: 4'b1001, exp_span: 0};
        vecs[2] = '{n_words: 5,  base: 8'h40, rpat: 4'b0101, exp_span: 0};
        vecs[3] = '{n_words: 12, base: 8'hC0, rpat: 4'b1111, exp_span: 12};

        // Reset, then idle
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pop", fifo_pop, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_beat", beat_cnt, 0);
        chk("rst_data", m_data, 0);
        do_reset();
        mon_en = 1'b1;
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
        end
        chk("idle_pops", pops, 0);

        // Single word latency
        m_ready = 1'b1;
        fifo_q.push_back(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = fifo_pop;
        end
        chk("single_pop_seen", seen, 1);
        @(negedge clk);
        chk("single_n1_valid", m_valid, 0);
        @(negedge clk);
        chk("single_n2_valid", m_valid, 1);
        chk("single_n2_data", m_data, 8'h5A);
        chk("single_n2_beat", beat_cnt, 0);
        @(negedge clk);
        chk("single_n3_valid", m_valid, 0);
`ifdef FIFO_RD_STREAM_LAST_EN
        chk("single_n3_beat", beat_cnt, 1);
`else
        chk("single_n3_beat", beat_cnt, 0);
`endif

        // Table-driven streaming runs
        foreach (vecs[v]) begin
            do_reset();
            run_beats = 0;
            k = 0;
            m_ready = vecs[v].rpat[0];
            for (int i = 0; i < vecs[v].n_words; i++)
                fifo_q.push_back(vecs[v].base + W_DATA'(i));
            for (int t = 0; t < 300 && run_beats < vecs[v].n_words; t++) begin
                @(posedge clk);
                #1;
                k++;
                m_ready = vecs[v].rpat[k % 4];
            end
            chk("vec_done", run_beats, vecs[v].n_words);
            if (vecs[v].exp_span != 0)
                chk("vec_span", last_cyc - first_cyc + 1, vecs[v].exp_span);
            m_ready = 1'b0;
            repeat (4) @(negedge clk);
            chk("vec_no_extra", run_beats, vecs[v].n_words);
        end

        // Reset mid-stream: one word buffered, one in flight
        do_reset();
        m_ready = 1'b0;
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        fifo_q.push_back(8'hA3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        chk("mid_valid_seen", seen, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_valid", m_valid, 0);
        chk("mid_async_data", m_data, 0);
        chk("mid_async_pop", fifo_pop, 0);
        exp_q.delete();
        tb_beat    = 0;
        stall_prev = 1'b0;
        run_beats  = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        fifo_data = 8'hBD;
        rst       = 1'b0;
        m_ready   = 1'b1;
        for (int t = 0; t < 20 && run_beats < 1; t++) @(negedge clk);
        chk("mid_first_beat", run_beats, 1);
        repeat (5) @(negedge clk);
        chk("mid_no_extra", run_beats, 1);
        chk("mid_exp_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the dual-clock FIFO. It sits in the read clock domain, issues pops against the FIFO's `empty`/`pop`/`data_out` consumer port, and absorbs the one-cycle registered RAM read latency. It presents the data as a back-pressured valid/ready stream with optional burst framing (`m_last`), sustaining one word per cycle.

## Interface
- `W_DATA`, default 8: data width; matches the FIFO `data_t` width.
- `BURST_LEN`, default 4: beats per burst for `m_last` framing; legal range 2..256.
- `clk` input, 1 bit: read-domain clock; all logic is on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `fifo_empty` input, 1 bit: FIFO empty flag. It is valid in the cycle it is sampled.
- `fifo_pop` output, 1 bit: pop request to the FIFO.
- `fifo_data` input, `W_DATA` bits: FIFO read data, valid one cycle after an accepted pop.
- `m_valid` output, 1 bit: stream data valid.
- `m_ready` input, 1 bit: downstream ready.
- `m_data` output, `W_DATA` bits: stream data (head of the buffer).
- `m_last` output, 1 bit: marks the final beat of a burst.
- `beat_cnt` output, 8 bits: position within the current burst.

## Operation
- **Accepted pop:** `fifo_pop && !fifo_empty` in a cycle. `fifo_pop` is never asserted while `fifo_empty` = 1.
- **Internal state:**
  - 2-entry output buffer (head/tail registers, `count` 0..2).
  - 1-bit `inflight` flag, set for the cycle after an accepted pop.
  - Burst counter `beat_cnt`.
- **Pop rule:** `fifo_pop = !fifo_empty && (count + inflight - (m_valid && m_ready)) < 2`.
  - The buffer can therefore never overflow.
- **Capture:** when `inflight` = 1, `fifo_data` is written into the buffer at that cycle's clock edge.
- **Simultaneous write and read of the buffer:**
  - `count` is unchanged.
  - When `count` = 1, the head is replaced by the new word.
- **Stream side:**
  - `m_valid = (count != 0)`.
  - `m_data` = head entry.
  - A beat transfers when `m_valid && m_ready`.
  - `m_data` holds stable while `m_valid && !m_ready`.
- **Burst state machine (IDLE / ACTIVE):**
  - IDLE: `beat_cnt` = 0. The first transferred beat moves to ACTIVE with `beat_cnt` = 1.
  - ACTIVE: each transferred beat increments `beat_cnt`.
  - `m_last = m_valid && (beat_cnt == BURST_LEN-1)`.
  - A beat transferred with `m_last` returns to IDLE with `beat_cnt` = 0.
  - An empty FIFO does not end a burst; the burst waits for data.
- **Ordering:** words are delivered strictly in pop order; none is dropped or duplicated.

## Timing
- **Reset values:**
  - `fifo_pop` = 0, `m_valid` = 0, `m_last` = 0, `beat_cnt` = 0, `m_data` = 0.
  - `count` = 0, `inflight` = 0, state = IDLE.
- **Latency:** pop accepted in cycle N → `fifo_data` sampled at the end of N+1 → `m_valid` = 1 in N+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one pop and one beat per cycle.
- **Back-pressure:**
  - `m_ready` = 0 with `count` = 1 and `inflight` = 1 → `fifo_pop` = 0 that cycle.
  - With `count` = 2 → `fifo_pop` = 0.
- **Reset mid-operation:**
  - Asserting `rst` clears all state immediately, with no clock required.
  - Buffered and in-flight words are discarded. A word arriving on `fifo_data` in the first cycle after reset release is ignored.
- **Wrap-around:** `beat_cnt` never exceeds `BURST_LEN-1`.

## Configuration
- Macro: `FIFO_RD_STREAM_LAST_EN`.
- Defined:
  - The burst state machine and `beat_cnt` register are compiled in.
  - `m_last` and `beat_cnt` behave as described above.
- Undefined:
  - The burst logic is omitted.
  - `m_last` and `beat_cnt` are tied to 0.
  - Data path and timing are identical.

## Test plan
- **Reset, then idle:** `rst` pulsed with `fifo_empty` = 1 → all outputs 0, and `fifo_pop` never asserts for 20 cycles.
- **Single word:** FIFO holds 0x5A, `m_ready` = 1 → pop in cycle N; `m_valid` = 1 with `m_data` = 0x5A in N+2 for exactly one cycle; `beat_cnt` goes from 0 to 1.
- **Streaming:** 8 words 0x00..0x07, `m_ready` = 1 → 8 consecutive beats with no bubbles, in order. With `FIFO_RD_STREAM_LAST_EN` defined, `m_last` is set on 0x03 and 0x07.
- **Back-pressure:** 8 words, `m_ready` toggling 1,0,0,1,… → `count` never exceeds 2, all 8 words delivered in order, and `m_data` stable across stalled cycles.
- **Reset mid-stream:** `rst` asserted one cycle after a pop, with one word buffered → `m_valid` falls to 0 asynchronously. After release, the next FIFO word appears as the first beat with `beat_cnt` = 0.
- **Macro off:** same stimulus as the streaming test → identical `m_data` sequence and timing; `m_last` and `beat_cnt` constant 0.
